// File: rtl/gray_step_decoder.sv
// gray_step_decoder: receives a Gray-coded up/down count, converts it to
// binary, decodes each step (+1, -1, -2) between consecutive samples and
// unwraps the modulo-2^N count into a signed P-bit position.
// Any other step is reported as an error and counted in a saturating counter.
module gray_step_decoder #(
  parameter int N = 4,
  parameter int P = 16,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] gray_in,
  output logic [N-1:0] bin_out,
  output logic [1:0]   step,
  output logic         step_valid,
  output logic         err,
  output logic [P-1:0] pos,
  output logic [E-1:0] err_cnt,
  output logic         locked
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [N-1:0] dec_s;
  logic [N-1:0] delta_s;
  logic         legal_s;

  logic [N-1:0] bin_nxt_s;
  logic [1:0]   step_nxt_s;
  logic         step_valid_nxt_s;
  logic         err_nxt_s;
  logic [P-1:0] pos_nxt_s;
  logic [E-1:0] err_cnt_nxt_s;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Legal deltas are +1, -1 and -2 in N-bit two's complement (for N=2, +2 aliases -2).
  function automatic logic is_legal_step(input logic [N-1:0] d);
    return (d == {{(N-1){1'b0}}, 1'b1}) ||
           (d == {N{1'b1}}) ||
           (d == {{(N-1){1'b1}}, 1'b0});
  endfunction

  assign dec_s   = gray_to_bin(gray_in);
  assign delta_s = dec_s - bin_out;
  assign legal_s = is_legal_step(delta_s);

  // State register plus every registered output; reset wins over en and clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_EMPTY;
      bin_out    <= {N{1'b0}};
      step       <= 2'b00;
      step_valid <= 1'b0;
      err        <= 1'b0;
      pos        <= {P{1'b0}};
      err_cnt    <= {E{1'b0}};
      locked     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bin_out    <= bin_nxt_s;
      step       <= step_nxt_s;
      step_valid <= step_valid_nxt_s;
      err        <= err_nxt_s;
      pos        <= pos_nxt_s;
      err_cnt    <= err_cnt_nxt_s;
      locked     <= (state_nxt_s == ST_TRACK);
    end
  end

  // Next state: clr drops back to EMPTY, any accepted sample leads to TRACK.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ST_EMPTY;
    end else if (en) begin
      state_nxt_s = ST_TRACK;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next datapath values: first sample seeds pos, later samples step it or flag an error.
  always_comb begin
    bin_nxt_s        = bin_out;
    step_nxt_s       = step;
    step_valid_nxt_s = 1'b0;
    err_nxt_s        = 1'b0;
    pos_nxt_s        = pos;
    err_cnt_nxt_s    = err_cnt;
    if (clr) begin
      bin_nxt_s = bin_out;
    end else if (en) begin
      case (state_r)
        ST_EMPTY: begin
          bin_nxt_s = dec_s;
          pos_nxt_s = {{(P-N){1'b0}}, dec_s};
        end
        ST_TRACK: begin
          bin_nxt_s = dec_s;
          if (legal_s) begin
            step_nxt_s       = delta_s[1:0];
            step_valid_nxt_s = 1'b1;
            pos_nxt_s        = pos + {{(P-N){delta_s[N-1]}}, delta_s};
          end else begin
            err_nxt_s = 1'b1;
            if (err_cnt != {E{1'b1}}) begin
              err_cnt_nxt_s = err_cnt + {{(E-1){1'b0}}, 1'b1};
            end else begin
              err_cnt_nxt_s = err_cnt;
            end
          end
        end
        default: begin
          bin_nxt_s = bin_out;
        end
      endcase
    end else begin
      bin_nxt_s = bin_out;
    end
  end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Testbench for gray_step_decoder (N=4, P=16, E=8): directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a behavioural model built on integer arithmetic.
module tb_gray_step_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  gray_in = 4'd0;
  logic [3:0]  bin_out;
  logic [1:0]  step;
  logic        step_valid;
  logic        err;
  logic [15:0] pos;
  logic [7:0]  err_cnt;
  logic        locked;

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;

  // model state
  bit          m_have;
  logic [3:0]  m_ref;
  logic [15:0] m_pos;
  logic [7:0]  m_ecnt;
  logic [1:0]  m_step;
  bit          m_sv;
  bit          m_er;

  gray_step_decoder #(.N(4), .P(16), .E(8)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .gray_in(gray_in),
    .bin_out(bin_out), .step(step), .step_valid(step_valid), .err(err),
    .pos(pos), .err_cnt(err_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // prefix-XOR of the Gray word gives its binary value
  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] m_b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit c, input logic [3:0] g);
    logic [3:0] dec;
    int d;
    if (r) begin
      m_have = 0; m_ref = 4'd0; m_pos = 16'd0; m_ecnt = 8'd0;
      m_step = 2'd0; m_sv = 0; m_er = 0;
    end else if (c) begin
      m_have = 0; m_sv = 0; m_er = 0;
    end else if (e) begin
      dec = m_g2b(g);
      if (!m_have) begin
        m_have = 1; m_ref = dec; m_pos = {12'd0, dec}; m_sv = 0; m_er = 0;
      end else begin
        d = (int'(dec) - int'(m_ref)) & 15;
        if (d >= 8) d -= 16;
        if (d == 1 || d == -1 || d == -2) begin
          m_step = 2'(d & 3);
          m_pos  = m_pos + 16'(d);
          m_sv = 1; m_er = 0;
        end else begin
          m_sv = 0; m_er = 1;
          if (m_ecnt < 8'd255) m_ecnt = m_ecnt + 8'd1;
        end
        m_ref = dec;
      end
    end else begin
      m_sv = 0; m_er = 0;
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit c, input logic [3:0] g);
    @(negedge clk);
    reset = r; en = e; clr = c; gray_in = g;
    @(posedge clk);
    model_step(r, e, c, g);
    #1;
  endtask

  // compare every output against the model once per cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("bin_out",    32'(bin_out),    32'(m_ref));
      chk("step",       32'(step),       32'(m_step));
      chk("step_valid", 32'(step_valid), 32'(m_sv));
      chk("err",        32'(err),        32'(m_er));
      chk("pos",        32'(pos),        32'(m_pos));
      chk("err_cnt",    32'(err_cnt),    32'(m_ecnt));
      chk("locked",     32'(locked),     32'(m_have));
      chk("sv_err_excl", 32'(step_valid & err), 32'd0);
    end
  end

  initial begin
    int ch;
    logic [3:0] tgt;
    tick(1'b1, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 1'b0, 1'b0, 4'b0000);
    chk_on = 1'b1;
    chk("rst_pos", 32'(pos), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);

    tick(1'b0, 1'b1, 1'b0, 4'b0000);
    chk("first_locked", 32'(locked), 32'h1);
    chk("first_sv", 32'(step_valid), 32'h0);
    tick(1'b0, 1'b1, 1'b0, 4'b0001);
    chk("up_step", 32'(step), 32'h1);
    chk("up_pos", 32'(pos), 32'h1);
    tick(1'b0, 1'b1, 1'b0, 4'b1000);
    chk("wrap_step", 32'(step), 32'h2);
    chk("wrap_pos", 32'(pos), 32'hFFFF);
    tick(1'b0, 1'b1, 1'b0, 4'b1001);
    chk("dn_step", 32'(step), 32'h3);
    chk("dn_pos", 32'(pos), 32'hFFFE);
    tick(1'b0, 1'b1, 1'b0, 4'b1001);
    chk("zero_err", 32'(err), 32'h1);
    chk("zero_pos", 32'(pos), 32'hFFFE);
    chk("zero_cnt", 32'(err_cnt), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 4'b0000);
    chk("idle_err", 32'(err), 32'h0);
    tick(1'b0, 1'b1, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 1'b0, 4'b0010);
    chk("p3_err", 32'(err), 32'h1);
    chk("p3_bin", 32'(bin_out), 32'h3);
    chk("p3_cnt", 32'(err_cnt), 32'h3);
    tick(1'b0, 1'b1, 1'b0, 4'b0110);
    chk("p1_sv", 32'(step_valid), 32'h1);
    chk("p1_pos", 32'(pos), 32'hFFFF);

    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 1'b0, 4'b0110);
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    tick(1'b1, 1'b1, 1'b0, 4'b0101);
    chk("mid_rst_cnt", 32'(err_cnt), 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_bin", 32'(bin_out), 32'h0);

    tick(1'b0, 1'b1, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 1'b0, 4'b0001);
    tick(1'b0, 1'b1, 1'b1, 4'b0101);
    chk("clr_locked", 32'(locked), 32'h0);
    chk("clr_pos", 32'(pos), 32'h1);
    tick(1'b0, 1'b1, 1'b0, 4'b0111);
    chk("reload_pos", 32'(pos), 32'h5);
    chk("reload_sv", 32'(step_valid), 32'h0);
    chk("reload_locked", 32'(locked), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      ch = int'($urandom_range(0, 7));
      case (ch)
        0, 1:    tgt = m_ref + 4'd1;
        2, 3:    tgt = m_ref - 4'd1;
        4:       tgt = m_ref - 4'd2;
        default: tgt = 4'($urandom_range(0, 15));
      endcase
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), m_b2g(tgt));
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
